rr_req_ack_arbiter: RTL
=======================

Name: rr_req_ack_arbiter

Overview:
- Round-robin arbiter and handshake sequencer that shares one req/ack responder among N_REQ clients.
- Grants one client at a time and issues a single-cycle req pulse to the responder.
- Waits an unbounded or bounded number of cycles for a rising ack, then returns a per-client done or timeout-error pulse.
- Sits between client request lines and the shared responder; its req_out/ack_in pair is the handshake checked by the team's req→ack liveness assertions.

Parameters:
- N_REQ, 4, number of requesting clients (2..16).
- TIMEOUT, 16, maximum WAIT cycles before abort; 0 disables the timeout (wait forever).
- CW, $clog2(TIMEOUT+1) (minimum 1), internal wait-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  N_REQ  level request per client; held until that client's done or err.
- ack_in  input  1  responder acknowledge; only its rising edge is meaningful.
- gnt  output  N_REQ  one-hot grant, held for the whole transaction.
- req_out  output  1  one-cycle request pulse to the responder.
- done  output  N_REQ  one-cycle completion pulse to the granted client.
- err  output  N_REQ  one-cycle timeout pulse to the granted client.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt=0, req_out=0, done=0, err=0, busy=0, rr pointer=0, ack_q=0, wait counter=0. Reset mid-transaction aborts it silently; no done or err is issued.
- ack_q <= ack_in every cycle. ack_rise = ack_in & ~ack_q.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req_in != 0, select the first set bit searching from the pointer upward with wrap.
  - Register it into gnt and go to ISSUE; otherwise stay in IDLE.
- ISSUE:
  - req_out=1 for exactly this cycle; wait counter cleared; go to WAIT.
  - An ack_rise in this cycle is ignored: ack must rise at least 1 cycle after req_out.
- WAIT:
  - On ack_rise: set the result flag to OK and go to RESP.
  - Otherwise, if TIMEOUT != 0 and the counter == TIMEOUT-1: set the result flag to ERR and go to RESP.
  - Otherwise increment the counter.
  - If ack_rise and timeout coincide, ack wins (OK).
- RESP:
  - done[granted] = 1 if OK, else err[granted] = 1, for one cycle.
  - Pointer <= granted index + 1, mod N_REQ. Go to IDLE; gnt clears on entry to IDLE.
- gnt is registered, one-hot, and nonzero in ISSUE, WAIT and RESP only.
- Latency:
  - req_in sampled in IDLE at cycle 0; gnt and req_out high in cycle 1.
  - WAIT from cycle 2. An ack_rise in cycle k (k≥2) gives done in cycle k+1 and IDLE in cycle k+2.
  - Minimum transaction is 4 cycles; back-to-back grants are separated by one IDLE cycle.
- A client dropping req_in mid-transaction does not abort it; done/err still pulses to that index.
- Clients whose req_in is high in IDLE but not selected keep waiting. The fairness bound is N_REQ-1 other transactions.
- ack_in held high across transactions produces no rise and is therefore never treated as an acknowledge.
- With TIMEOUT=0, WAIT persists indefinitely until ack_rise.

Test Plan:
- Single client: req_in=4'b0001, ack_in rises 3 cycles after req_out → gnt=0001 for 5 cycles, one req_out pulse, done=0001 exactly 1 cycle after the ack rise, err never set.
- Round robin: req_in=4'b1111 held, ack_in rises 2 cycles after each req_out → grant order 0,1,2,3,0; one IDLE cycle between grants.
- Timeout: TIMEOUT=16, req_in=0010, ack_in held 0 → err=0010 pulse 17 cycles after req_out, no done, then back to IDLE.
- Ack/timeout coincidence and stale ack: ack rises in the last WAIT cycle → done, not err. ack_in already high at ISSUE and held high → no rise, timeout err.
- Reset mid-WAIT: drop rst_n while busy=1 → all outputs 0 immediately, pointer=0. After release with req_in=1000|0001, client 0 is granted first.
- TIMEOUT=0: ack delayed 200 cycles → no err, done after the rise. req_in dropped during WAIT → done still pulses to the granted index.

Source files
------------

// File: rtl/rr_req_ack_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_req_ack_arbiter_if
//   Bundles the client-side request/grant lines and the shared responder
//   req/ack pair for rr_req_ack_arbiter.
//
//   Handshake: a client raises req_in[i] and holds it until done[i] or err[i]
//   pulses. The arbiter raises req_out for exactly one cycle per transaction
//   and accepts only a rising edge on ack_in, seen at least one cycle after
//   req_out, as the responder's acknowledge.
//
//   Signals:
//     req_in    [N_REQ] level request per client
//     ack_in    [1]     responder acknowledge (edge-qualified)
//     gnt       [N_REQ] one-hot grant, held for the whole transaction
//     req_out   [1]     one-cycle request pulse to the responder
//     done      [N_REQ] one-cycle completion pulse
//     err       [N_REQ] one-cycle timeout pulse
//     busy      [1]     arbiter is not idle
//     dbg_state [2]     current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
//   Modports: master = arbiter side, slave = clients/responder side.
// ---------------------------------------------------------------------------
interface rr_req_ack_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0] req_in;
   logic             ack_in;
   logic [N_REQ-1:0] gnt;
   logic             req_out;
   logic [N_REQ-1:0] done;
   logic [N_REQ-1:0] err;
   logic             busy;
   logic [1:0]       dbg_state;

   modport master (
      input  req_in, ack_in,
      output gnt, req_out, done, err, busy, dbg_state
   );

   modport slave (
      output req_in, ack_in,
      input  gnt, req_out, done, err, busy, dbg_state
   );
endinterface

// File: rtl/rr_req_ack_arbiter.sv
// ---------------------------------------------------------------------------
// rr_req_ack_arbiter
//   Round-robin arbiter that shares one req/ack responder among N_REQ
//   clients. One client is granted at a time; the arbiter pulses req_out,
//   waits for a rising ack_in (optionally bounded by TIMEOUT cycles) and
//   answers the granted client with a one-cycle done or err pulse.
//
//   Ports:
//     clk    system clock, all state on posedge
//     rst_n  asynchronous active-low reset
//     bus    rr_req_ack_arbiter_if.master (req_in, ack_in, gnt, req_out,
//            done, err, busy, dbg_state)
//
//   Parameters:
//     N_REQ    number of clients (2..16)
//     TIMEOUT  max WAIT cycles before abort; 0 waits forever
// ---------------------------------------------------------------------------
module rr_req_ack_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   rr_req_ack_arbiter_if.master   bus
);

   localparam int PW = $clog2(N_REQ);
   localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]    TMAX     = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
   localparam logic [PW-1:0]    LAST_IDX = PW'(N_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q;
   logic [PW-1:0]    gidx_q;
   logic [PW-1:0]    ptr_q;
   logic [CW-1:0]    cnt_q;
   logic             ack_q;
   logic             ok_q;

   logic             ack_rise;
   logic             timeout_hit;
   logic             sel_found;
   logic [PW-1:0]    sel_idx;
   int               cand;

   logic             req_out_c;
   logic [N_REQ-1:0] done_c;
   logic [N_REQ-1:0] err_c;
   logic             busy_c;

   assign ack_rise    = bus.ack_in & ~ack_q;
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TMAX);

   // Search upward from the pointer with wrap; the first requester wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = (int'(ptr_q) + i) % N_REQ;
         if (!sel_found && bus.req_in[PW'(cand)]) begin
            sel_found = 1'b1;
            sel_idx   = PW'(cand);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and outputs. Outputs decode from registered state, so an
   // asynchronous reset forces them low immediately.
   always_comb begin
      state_d   = state_q;
      req_out_c = 1'b0;
      done_c    = '0;
      err_c     = '0;
      busy_c    = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (sel_found) state_d = ISSUE;
         end
         ISSUE: begin
            req_out_c = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            // An ack rise beats a coincident timeout.
            if (ack_rise || timeout_hit) state_d = RESP;
         end
         RESP: begin
            if (ok_q) done_c = gnt_q;
            else      err_c  = gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Grant, pointer, wait counter and result flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q  <= '0;
         gidx_q <= '0;
         ptr_q  <= '0;
         cnt_q  <= '0;
         ack_q  <= 1'b0;
         ok_q   <= 1'b0;
      end else begin
         ack_q <= bus.ack_in;
         case (state_q)
            IDLE: begin
               if (sel_found) begin
                  gnt_q  <= ONE_HOT0 << sel_idx;
                  gidx_q <= sel_idx;
               end
            end
            ISSUE: begin
               cnt_q <= '0;
            end
            WAIT: begin
               if (ack_rise)         ok_q  <= 1'b1;
               else if (timeout_hit) ok_q  <= 1'b0;
               else if (TIMEOUT != 0) cnt_q <= cnt_q + CW'(1);
            end
            RESP: begin
               gnt_q <= '0;
               ptr_q <= (gidx_q == LAST_IDX) ? '0 : gidx_q + PW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.req_out   = req_out_c;
   assign bus.done      = done_c;
   assign bus.err       = err_c;
   assign bus.busy      = busy_c;
   assign bus.dbg_state = state_q;

endmodule
